// File: rtl/p2s_stream_arbiter.sv
// Round-robin arbiter with bounded bursts, sharing one parallel-to-serial converter
// between M requesters; the grant is held while the serializer shifts a word out.
module p2s_stream_arbiter #(
    parameter  int N     = 8,
    parameter  int M     = 4,
    parameter  int BURST = 2,
    localparam int IW    = $clog2(M),
    localparam int BW    = $clog2(BURST + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [M-1:0]      req_valid,
    input  logic [M*N-1:0]    req_data,
    output logic [M-1:0]      req_ready,
    output logic              ser_par_valid,
    output logic [N-1:0]      ser_par_data,
    input  logic              ser_par_ready,
    output logic [IW-1:0]     grant_id,
    output logic              busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]   grant_id_nxt;
    logic [BW-1:0]   burst_cnt, burst_cnt_nxt;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   scan_idx;
    logic            found;

    // Modulo-M increment: never yields an index >= M, even for non-power-of-2 M.
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (i == IW'(M - 1)) ? '0 : i + 1'b1;
    endfunction

    // NOTE: scan_idx is updated with blocking assignments on purpose; each loop
    // iteration must see the previous iteration's value within the same evaluation.
    always_comb begin
        pick     = rr_ptr;
        found    = 1'b0;
        scan_idx = rr_ptr;
        for (int k = 0; k < M; k++) begin
            if (!found && req_valid[scan_idx]) begin
                pick  = scan_idx;
                found = 1'b1;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    // NOTE: every sequential element uses non-blocking assignment so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant_id  <= grant_id_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // NOTE: each output of a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        grant_id_nxt  = grant_id;
        burst_cnt_nxt = burst_cnt;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_id_nxt  = pick;
                    burst_cnt_nxt = '0;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                // While the serializer shifts (ready low) the grant simply holds.
                if (ser_par_ready) begin
                    if (req_valid[grant_id] && burst_cnt != BW'(BURST - 1)) begin
                        burst_cnt_nxt = burst_cnt + 1'b1;
                    end else begin
                        state_nxt     = IDLE;
                        rr_ptr_nxt    = wrap_inc(grant_id);
                        burst_cnt_nxt = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are gated by rstn so a word offered during a reset cycle
    // is never seen as accepted by either side.
    always_comb begin
        req_ready     = '0;
        ser_par_valid = 1'b0;
        ser_par_data  = req_data[int'(grant_id) * N +: N];
        busy          = (state == GRANT);
        if (state == GRANT && rstn) begin
            ser_par_valid       = req_valid[grant_id];
            req_ready[grant_id] = ser_par_ready;
        end
    end

endmodule

// File: tb/tb_p2s_stream_arbiter.sv
// Bench for p2s_stream_arbiter: queued producers and a serializer model drive the DUT;
// a monitor checks handshakes, grant order and word data against a reference model.
module tb_p2s_stream_arbiter;

    localparam int N     = 8;
    localparam int M     = 4;
    localparam int BURST = 2;

    logic           clk = 1'b0;
    logic           rstn;
    logic [M-1:0]   req_valid;
    logic [M*N-1:0] req_data;
    logic [M-1:0]   req_ready;
    logic           ser_par_valid;
    logic [N-1:0]   ser_par_data;
    logic           ser_par_ready;
    logic [1:0]     grant_id;
    logic           busy;

    p2s_stream_arbiter #(.N(N), .M(M), .BURST(BURST)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .ser_par_valid(ser_par_valid), .ser_par_data(ser_par_data),
        .ser_par_ready(ser_par_ready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Producer queues, expected-word scoreboard and grant log.
    logic [N-1:0] prod_q [M][$];
    logic [N-1:0] exp_q  [M][$];
    int           grant_log [$];
    bit           pv [M];
    logic [N-1:0] pdata [M];
    int           gap_pct = 0;
    int           tx_len  = 2;
    bit           tx_rand = 1'b0;
    int           ser_tx  = 0;

    task automatic load(input int i, input logic [N-1:0] d);
        prod_q[i].push_back(d);
        exp_q[i].push_back(d);
    endtask

    // Producers hold a word until accepted; serializer is ready only while idle.
    initial begin
        req_valid     = '0;
        req_data      = '0;
        ser_par_ready = 1'b1;
        forever begin
            @(negedge clk);
            for (int i = 0; i < M; i++) begin
                if (!pv[i] && prod_q[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
                    pv[i]    = 1'b1;
                    pdata[i] = prod_q[i].pop_front();
                end
                req_valid[i]        = pv[i];
                req_data[i*N +: N]  = pdata[i];
            end
            ser_par_ready = (ser_tx == 0);
            #3;
            for (int i = 0; i < M; i++)
                if (pv[i] && req_ready[i]) pv[i] = 1'b0;
            if (ser_par_valid && ser_par_ready)
                ser_tx = tx_rand ? int'($urandom_range(8, 1)) : tx_len;
            else if (ser_tx > 0)
                ser_tx--;
        end
    end

    // Reference model: grant state at transaction level plus scoreboard pop.
    bit           m_init = 1'b0;
    bit           m_busy = 1'b0;
    int           m_gid  = 0;
    int           m_rr   = 0;
    int           m_cnt  = 0;
    logic [M-1:0] exp_rdy;
    bit           exp_v;
    logic [N-1:0] exp_word;

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (m_init) begin
                exp_rdy = '0;
                exp_v   = 1'b0;
                if (rstn && m_busy) begin
                    exp_rdy[m_gid] = ser_par_ready;
                    exp_v          = req_valid[m_gid];
                end
                check("busy", busy, m_busy);
                check("grant_id", grant_id, m_gid);
                check("req_ready", req_ready, exp_rdy);
                check("ser_par_valid", ser_par_valid, exp_v);
                if (exp_v) check("ser_par_data", ser_par_data, req_data[m_gid*N +: N]);
                if (ser_par_valid && ser_par_ready) begin
                    if (exp_q[m_gid].size() == 0) begin
                        check("unexpected_word", 32'(ser_par_data), 32'hFFFF_FFFF);
                    end else begin
                        exp_word = exp_q[m_gid].pop_front();
                        check("word_data", ser_par_data, exp_word);
                    end
                end
            end
            if (!rstn) begin
                m_init = 1'b1;
                m_busy = 1'b0;
                m_gid  = 0;
                m_rr   = 0;
                m_cnt  = 0;
            end else if (m_init) begin
                if (!m_busy) begin
                    for (int k = 0; k < M; k++) begin
                        if (!m_busy && req_valid[(m_rr + k) % M]) begin
                            m_gid  = (m_rr + k) % M;
                            m_busy = 1'b1;
                            m_cnt  = 0;
                            grant_log.push_back(m_gid);
                        end
                    end
                end else if (ser_par_ready) begin
                    if (req_valid[m_gid]) m_cnt++;
                    if (!req_valid[m_gid] || m_cnt == BURST) begin
                        m_busy = 1'b0;
                        m_rr   = (m_gid + 1) % M;
                        m_cnt  = 0;
                    end
                end
            end
        end
    end

    task automatic drain(input int budget);
        bit done = 1'b0;
        bit idle;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            #4;
            idle = !busy && ser_tx == 0;
            for (int i = 0; i < M; i++)
                if (pv[i] || prod_q[i].size() > 0) idle = 1'b0;
            done = idle;
        end
        check("drain_timeout", done, 1'b1);
    endtask

    task automatic wait_cycles_until_busy(input int budget, input bit need_shift);
        bit hit = 1'b0;
        for (int c = 0; c < budget && !hit; c++) begin
            @(negedge clk);
            #4;
            hit = busy && (!need_shift || !ser_par_ready);
        end
        check("busy_timeout", hit, 1'b1);
    endtask

    int base;

    initial begin
        rstn = 1'b0;
        for (int i = 0; i < M; i++) load(i, 8'h10 + 8'(i));

        // Reset with every requester valid.
        repeat (2) @(negedge clk);
        #4;
        check("rst_ser_par_valid", ser_par_valid, 1'b0);
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_grant_id", grant_id, 0);
        check("rst_all_valid", req_valid, 4'b1111);
        @(negedge clk);
        rstn = 1'b1;
        #4;
        check("arb_cycle_idle", busy, 1'b0);
        @(negedge clk);
        #4;
        check("first_grant_busy", busy, 1'b1);
        check("first_grant_id", grant_id, 0);
        drain(500);

        // Round-robin fairness: four words from every requester.
        base = grant_log.size();
        @(negedge clk);
        #1;
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < M; i++) load(i, 8'((i << 4) | j));
        drain(2000);
        check("rr_grant_count", grant_log.size() - base, 8);
        for (int k = 0; k < 8; k++) check("rr_order", grant_log[base + k], k % M);

        // Single requester through full 8-cycle serializer TX.
        tx_len = 8;
        base   = grant_log.size();
        @(negedge clk);
        #1;
        load(2, 8'hA5);
        load(2, 8'h3C);
        drain(500);
        check("single_grants", grant_log.size() - base, 1);
        check("single_grant_id", grant_log[base], 2);

        // Wrap and skip: scan 3,0,1 then 2,3.
        tx_len = 2;
        base   = grant_log.size();
        @(negedge clk);
        #1;
        load(1, 8'h11);
        drain(500);
        check("wrap_grant", grant_log[base], 1);
        base = grant_log.size();
        @(negedge clk);
        #1;
        load(1, 8'h21);
        load(3, 8'h23);
        drain(500);
        check("skip_grant_first", grant_log[base], 3);
        check("skip_grant_second", grant_log[base + 1], 1);

        // Early release: requester 1 sends one word, pending requester 0 follows.
        base = grant_log.size();
        @(negedge clk);
        #1;
        load(1, 8'h77);
        wait_cycles_until_busy(50, 1'b0);
        load(0, 8'h66);
        drain(500);
        check("early_grant_first", grant_log[base], 1);
        check("early_grant_next", grant_log[base + 1], 0);

        // Reset while the serializer is shifting.
        tx_len = 8;
        @(negedge clk);
        #1;
        load(2, 8'hD1);
        load(2, 8'hD2);
        wait_cycles_until_busy(50, 1'b1);
        @(negedge clk);
        rstn = 1'b0;
        #4;
        check("midrst_ready_gated", req_ready, 4'b0000);
        @(negedge clk);
        rstn = 1'b1;
        #4;
        check("midrst_busy", busy, 1'b0);
        check("midrst_req_ready", req_ready, 4'b0000);
        check("midrst_word_pending", pv[2], 1'b1);
        drain(500);

        // Randomized traffic with producer gaps and variable TX length.
        gap_pct = 30;
        tx_rand = 1'b1;
        for (int w = 0; w < 200; w++) begin
            load(int'($urandom_range(M - 1)), 8'($urandom));
            if ($urandom_range(3) == 0) begin
                repeat ($urandom_range(5)) @(negedge clk);
                #1;
            end
        end
        drain(20000);

        for (int i = 0; i < M; i++) check("words_left", exp_q[i].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
